rv_mem_bridge: RTL and testbench

//  Initiator on the RISC-V side of the SDRAM memory controller's 16-bit rv port.

---
 rtl/rv_mem_bridge_pkg.sv | 34 +++
 rtl/rv_mem_bridge_if.sv | 32 +++
 rtl/rv_mem_bridge.sv | 174 +++++++++++++++++
 tb/tb_rv_mem_bridge.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_mem_bridge_pkg.sv
// Shared types and constants for the RISC-V side memory bridge.
package rv_mem_bridge_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LO_REQ,
      LO_ACK,
      LO_DONE,
      HI_REQ,
      HI_ACK,
      HI_DONE,
      RESP
   } rv_state_t;

   localparam logic RV_HALF_LO = 1'b0;
   localparam logic RV_HALF_HI = 1'b1;

   // Byte address in SDRAM where the RV window starts.
   localparam logic [22:0] RV_BASE = 23'h40_0000;

   // Byte selects for one halfword; an all-zero strobe word is a read of both bytes.
   function automatic logic [1:0] half_ds(input logic [3:0] wstrb, input logic half);
      if (wstrb == 4'b0000) begin
         return 2'b11;
      end
      return half ? wstrb[3:2] : wstrb[1:0];
   endfunction

   // Absolute SDRAM byte address of an rv halfword address.
   function automatic logic [22:0] sdram_byte_addr(input logic [21:0] hw_addr);
      return RV_BASE | {hw_addr, 1'b0};
   endfunction

endpackage

// File: rtl/rv_mem_bridge_if.sv
// Bus bundle between the softcore word bus, the bridge and the controller rv port.
// master: the bridge itself (initiator on the rv port, responder on the cpu bus).
// slave:  the surrounding environment (cpu plus memory controller).
interface rv_mem_bridge_if;

   logic        cpu_valid;
   logic        cpu_ready;
   logic [20:0] cpu_addr;
   logic [3:0]  cpu_wstrb;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_err;

   logic [21:0] rv_addr;
   logic [15:0] rv_din;
   logic [1:0]  rv_ds;
   logic        rv_we;
   logic        rv_req;
   logic        rv_req_ack;
   logic [15:0] rv_dout;

   modport master (
      input  cpu_valid, cpu_addr, cpu_wstrb, cpu_wdata, rv_req_ack, rv_dout,
      output cpu_ready, cpu_rdata, cpu_err, rv_addr, rv_din, rv_ds, rv_we, rv_req
   );

   modport slave (
      output cpu_valid, cpu_addr, cpu_wstrb, cpu_wdata, rv_req_ack, rv_dout,
      input  cpu_ready, cpu_rdata, cpu_err, rv_addr, rv_din, rv_ds, rv_we, rv_req
   );

endinterface

// File: rtl/rv_mem_bridge.sv
// Splits 32-bit cpu word accesses into low/high halfword requests on the
// controller's 16-bit rv port and reassembles read data. All rv outputs are
// registered so the controller's request mux never sees glitches.
module rv_mem_bridge
   import rv_mem_bridge_pkg::*;
#(
   parameter int TIMEOUT = 64,
   parameter int TO_W    = 7
) (
   input logic             clk,
   input logic             resetn,
   rv_mem_bridge_if.master bus
);

   rv_state_t       state;
   rv_state_t       state_next;
   logic [20:0]     addr_q;
   logic [31:0]     wdata_q;
   logic [3:0]      wstrb_q;
   logic [TO_W-1:0] to_cnt;

   logic        timeout;
   logic        to_expired;
   logic        accept;
   logic        enter_lo;
   logic        enter_hi;
   logic        leave_req;
   logic        is_read;
   logic        need_hi;
   logic        in_need_lo;
   logic [20:0] src_addr;
   logic [31:0] src_wdata;
   logic [3:0]  src_wstrb;

   assign is_read    = (wstrb_q == 4'b0000);
   assign need_hi    = is_read || (wstrb_q[3:2] != 2'b00);
   assign in_need_lo = (bus.cpu_wstrb == 4'b0000) || (bus.cpu_wstrb[1:0] != 2'b00);
   assign to_expired = (to_cnt == TO_W'(TIMEOUT - 1));

   assign src_addr  = (state == IDLE) ? bus.cpu_addr  : addr_q;
   assign src_wdata = (state == IDLE) ? bus.cpu_wdata : wdata_q;
   assign src_wstrb = (state == IDLE) ? bus.cpu_wstrb : wstrb_q;

   assign accept    = (state == IDLE) && (state_next != IDLE);
   assign enter_lo  = (state_next == LO_REQ) && (state != LO_REQ);
   assign enter_hi  = (state_next == HI_REQ) && (state != HI_REQ);
   assign leave_req = ((state == LO_REQ) || (state == HI_REQ)) && (state_next != state);

   // Next-state decode; a new word is never taken while the controller still acks.
   always_comb begin
      state_next = state;
      timeout    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.cpu_valid && !bus.cpu_ready && !bus.rv_req_ack) begin
               state_next = in_need_lo ? LO_REQ : HI_REQ;
            end
         end
         LO_REQ: begin
            if (bus.rv_req_ack) begin
               state_next = LO_ACK;
            end else if (to_expired) begin
               timeout    = 1'b1;
               state_next = RESP;
            end
         end
         LO_ACK: begin
            if (!bus.rv_req_ack) begin
               state_next = LO_DONE;
            end else if (to_expired) begin
               timeout    = 1'b1;
               state_next = RESP;
            end
         end
         LO_DONE: state_next = need_hi ? HI_REQ : RESP;
         HI_REQ: begin
            if (bus.rv_req_ack) begin
               state_next = HI_ACK;
            end else if (to_expired) begin
               timeout    = 1'b1;
               state_next = RESP;
            end
         end
         HI_ACK: begin
            if (!bus.rv_req_ack) begin
               state_next = HI_DONE;
            end else if (to_expired) begin
               timeout    = 1'b1;
               state_next = RESP;
            end
         end
         HI_DONE: state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Handshake watchdog: restarts on every state change, counts only while waiting on the controller.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         to_cnt <= '0;
      end else if (state_next != state) begin
         to_cnt <= '0;
      end else if ((state == LO_REQ) || (state == LO_ACK) ||
                   (state == HI_REQ) || (state == HI_ACK)) begin
         to_cnt <= to_cnt + TO_W'(1);
      end
   end

   // Capture the cpu payload once so later bus changes cannot disturb the transfer.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
      end else if (accept) begin
         addr_q  <= bus.cpu_addr;
         wdata_q <= bus.cpu_wdata;
         wstrb_q <= bus.cpu_wstrb;
      end
   end

   // Registered rv request: loaded on entry to a REQ state, dropped the cycle after ack or timeout.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bus.rv_req  <= 1'b0;
         bus.rv_we   <= 1'b0;
         bus.rv_ds   <= 2'b00;
         bus.rv_addr <= '0;
         bus.rv_din  <= '0;
      end else if (enter_lo || enter_hi) begin
         bus.rv_req  <= 1'b1;
         bus.rv_we   <= (src_wstrb != 4'b0000);
         bus.rv_ds   <= half_ds(src_wstrb, enter_hi);
         bus.rv_addr <= {src_addr, enter_hi ? RV_HALF_HI : RV_HALF_LO};
         bus.rv_din  <= enter_hi ? src_wdata[31:16] : src_wdata[15:0];
      end else if (leave_req) begin
         bus.rv_req  <= 1'b0;
      end
   end

   // cpu response: read-data assembly, one-cycle ready pulse and sticky error.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bus.cpu_ready <= 1'b0;
         bus.cpu_rdata <= '0;
         bus.cpu_err   <= 1'b0;
      end else begin
         bus.cpu_ready <= (state_next == RESP) && (state != RESP);
         if ((state == LO_DONE) && is_read) begin
            bus.cpu_rdata[15:0] <= bus.rv_dout;
         end
         if ((state == HI_DONE) && is_read) begin
            bus.cpu_rdata[31:16] <= bus.rv_dout;
         end
         if (timeout) begin
            bus.cpu_err <= 1'b1;
            if (is_read) begin
               bus.cpu_rdata <= 32'hFFFF_FFFF;
            end
         end
      end
   end

endmodule

// File: tb/tb_rv_mem_bridge.sv
// Directed bench for rv_mem_bridge with a cycle-stepped model of the
// controller's rv port (configurable ack delay/hold, one-cycle read data).
module tb_rv_mem_bridge;

   logic clk = 1'b0;
   logic resetn = 1'b0;

   always #5 clk = ~clk;

   rv_mem_bridge_if bus();

   rv_mem_bridge #(.TIMEOUT(64), .TO_W(7)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   typedef struct {
      logic [20:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      logic [15:0] lo;
      logic [15:0] hi;
      bit          hold_extra;
      int          n_req;
      int          lat;
      logic [21:0] addr0;
      logic [21:0] addr1;
      logic [1:0]  ds0;
      logic [1:0]  ds1;
      logic [15:0] din0;
      logic [15:0] din1;
      logic        we;
      logic [31:0] rdata;
   } vec_t;

   typedef enum int {M_IDLE, M_WAIT, M_HOLD, M_DATA, M_DATA2} mphase_t;

   int n_checks = 0;
   int n_fail   = 0;

   mphase_t     mphase = M_IDLE;
   int          mcnt = 0;
   int          ack_delay = 1;
   int          ack_hold = 4;
   bit          never_ack = 1'b0;
   logic [15:0] model_lo = 16'h0;
   logic [15:0] model_hi = 16'h0;
   logic [15:0] mdata = 16'h0;
   int          req_count = 0;
   logic [21:0] log_addr [8];
   logic [1:0]  log_ds [8];
   logic [15:0] log_din [8];
   logic        log_we [8];
   int          drop_viol = 0;
   int          reraise_viol = 0;
   int          ready_pulses = 0;

   // Controller model, stepped on the falling edge so it behaves like a registered peer.
   initial begin
      bus.rv_req_ack = 1'b0;
      bus.rv_dout    = 16'h0BAD;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            mphase         = M_IDLE;
            bus.rv_req_ack = 1'b0;
            bus.rv_dout    = 16'h0BAD;
         end else begin
            if (bus.cpu_ready) ready_pulses++;
            if (bus.rv_req && bus.rv_req_ack) reraise_viol++;
            case (mphase)
               M_WAIT: begin
                  if (!bus.rv_req) begin
                     if (!never_ack) drop_viol++;
                     mphase = M_IDLE;
                  end else if (!never_ack) begin
                     if (mcnt <= 1) begin
                        bus.rv_req_ack = 1'b1;
                        mcnt           = ack_hold;
                        mphase         = M_HOLD;
                     end else begin
                        mcnt--;
                     end
                  end
               end
               M_HOLD: begin
                  if (mcnt <= 1) begin
                     bus.rv_req_ack = 1'b0;
                     mphase         = M_DATA;
                  end else begin
                     mcnt--;
                  end
               end
               M_DATA: begin
                  bus.rv_dout = mdata;
                  mphase      = M_DATA2;
               end
               M_DATA2: begin
                  bus.rv_dout = 16'h0BAD;
                  mphase      = M_IDLE;
               end
               default: ;
            endcase
            if (mphase == M_IDLE && bus.rv_req) begin
               if (req_count < 8) begin
                  log_addr[req_count] = bus.rv_addr;
                  log_ds[req_count]   = bus.rv_ds;
                  log_din[req_count]  = bus.rv_din;
                  log_we[req_count]   = bus.rv_we;
               end
               req_count++;
               mdata  = bus.rv_addr[0] ? model_hi : model_lo;
               mcnt   = ack_delay;
               mphase = M_WAIT;
            end
         end
      end
   end

   // Simulation time limit.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: time limit reached before end of test");
      $fatal(1, "[TB] time limit");
   end

   task automatic checkValue(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkValue({tag, "_cpu_ready"}, bus.cpu_ready, 0);
      checkValue({tag, "_cpu_rdata"}, bus.cpu_rdata, 0);
      checkValue({tag, "_cpu_err"},   bus.cpu_err, 0);
      checkValue({tag, "_rv_req"},    bus.rv_req, 0);
      checkValue({tag, "_rv_we"},     bus.rv_we, 0);
      checkValue({tag, "_rv_ds"},     bus.rv_ds, 0);
      checkValue({tag, "_rv_addr"},   bus.rv_addr, 0);
      checkValue({tag, "_rv_din"},    bus.rv_din, 0);
   endtask

   // Issue one word access, scramble the payload once it is taken, and wait (bounded) for ready.
   task automatic applyStimulus(input vec_t v, output int lat, output logic [31:0] rdata, output bit got);
      model_lo     = v.lo;
      model_hi     = v.hi;
      req_count    = 0;
      ready_pulses = 0;
      for (int i = 0; i < 8; i++) begin
         log_addr[i] = 'x;
         log_ds[i]   = 'x;
         log_din[i]  = 'x;
         log_we[i]   = 1'bx;
      end
      bus.cpu_addr  = v.addr;
      bus.cpu_wstrb = v.wstrb;
      bus.cpu_wdata = v.wdata;
      bus.cpu_valid = 1'b1;
      lat   = 0;
      rdata = 32'h0;
      got   = 1'b0;
      @(posedge clk);
      #1;
      bus.cpu_addr  = ~v.addr;
      bus.cpu_wstrb = ~v.wstrb;
      bus.cpu_wdata = ~v.wdata;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         #1;
         if (bus.cpu_ready) begin
            got   = 1'b1;
            rdata = bus.cpu_rdata;
            break;
         end
         lat++;
      end
      if (v.hold_extra) begin
         @(negedge clk);
         #1;
      end
      bus.cpu_valid = 1'b0;
      repeat (4) @(negedge clk);
      #1;
   endtask

   task automatic checkOutput(input vec_t v, input string tag, input int lat,
                              input logic [31:0] rdata, input bit got);
      logic [21:0] exp_addr;
      logic [1:0]  exp_ds;
      logic [15:0] exp_din;
      checkValue({tag, "_ready_seen"}, got, 1);
      checkValue({tag, "_ready_pulses"}, ready_pulses, 1);
      checkValue({tag, "_req_count"}, req_count, v.n_req);
      checkValue({tag, "_latency"}, lat, v.lat);
      checkValue({tag, "_rdata"}, rdata, v.rdata);
      for (int i = 0; i < 2; i++) begin
         if (i < v.n_req) begin
            exp_addr = (i == 0) ? v.addr0 : v.addr1;
            exp_ds   = (i == 0) ? v.ds0 : v.ds1;
            exp_din  = (i == 0) ? v.din0 : v.din1;
            checkValue($sformatf("%s_rv_addr%0d", tag, i), log_addr[i], exp_addr);
            checkValue($sformatf("%s_rv_ds%0d", tag, i), log_ds[i], exp_ds);
            checkValue($sformatf("%s_rv_we%0d", tag, i), log_we[i], v.we);
            if (v.we) begin
               checkValue($sformatf("%s_rv_din%0d", tag, i), log_din[i], exp_din);
            end
         end
      end
   endtask

   vec_t vecs [9];
   vec_t vdelay;
   vec_t vtime;

   initial begin
      int          lat;
      int          waited;
      logic [31:0] rd;
      bit          got;

      //              addr        wstrb    wdata          lo        hi        hx n  lat addr0       addr1       ds0    ds1    din0      din1      we    rdata
      vecs[0] = '{21'h00010, 4'b0000, 32'h0000_0000, 16'hBEEF, 16'hDEAD, 0, 2, 14, 22'h00020,  22'h00021,  2'b11, 2'b11, 16'h0000, 16'h0000, 1'b0, 32'hDEAD_BEEF};
      vecs[1] = '{21'h00010, 4'b1100, 32'h1234_5678, 16'h0000, 16'h0000, 0, 1, 7,  22'h00021,  22'h00000,  2'b11, 2'b00, 16'h1234, 16'h0000, 1'b1, 32'hDEAD_BEEF};
      vecs[2] = '{21'h00123, 4'b0010, 32'h0000_AB00, 16'h0000, 16'h0000, 1, 1, 7,  22'h00246,  22'h00000,  2'b10, 2'b00, 16'hAB00, 16'h0000, 1'b1, 32'hDEAD_BEEF};
      vecs[3] = '{21'h1ABCD, 4'b1111, 32'hCAFE_F00D, 16'h0000, 16'h0000, 0, 2, 14, 22'h3579A,  22'h3579B,  2'b11, 2'b11, 16'hF00D, 16'hCAFE, 1'b1, 32'hDEAD_BEEF};
      vecs[4] = '{21'h00007, 4'b0101, 32'h1122_3344, 16'h0000, 16'h0000, 0, 2, 14, 22'h0000E,  22'h0000F,  2'b01, 2'b01, 16'h3344, 16'h1122, 1'b1, 32'hDEAD_BEEF};
      vecs[5] = '{21'h1FFFFF,4'b0000, 32'h0000_0000, 16'h1357, 16'h2468, 0, 2, 14, 22'h3FFFFE, 22'h3FFFFF, 2'b11, 2'b11, 16'h0000, 16'h0000, 1'b0, 32'h2468_1357};
      vecs[6] = '{21'h00001, 4'b1000, 32'hAA00_0000, 16'h0000, 16'h0000, 1, 1, 7,  22'h00003,  22'h00000,  2'b10, 2'b00, 16'hAA00, 16'h0000, 1'b1, 32'h2468_1357};
      vecs[7] = '{21'h0ABCD, 4'b0000, 32'h5555_AAAA, 16'h0000, 16'hFFFF, 0, 2, 14, 22'h1579A,  22'h1579B,  2'b11, 2'b11, 16'h0000, 16'h0000, 1'b0, 32'hFFFF_0000};
      vecs[8] = '{21'h00400, 4'b0000, 32'h0000_0000, 16'h5A5A, 16'hA5A5, 0, 2, 14, 22'h00800,  22'h00801,  2'b11, 2'b11, 16'h0000, 16'h0000, 1'b0, 32'hA5A5_5A5A};
      vdelay  = '{21'h00300, 4'b0000, 32'h0000_0000, 16'h0102, 16'h0304, 0, 2, 38, 22'h00600,  22'h00601,  2'b11, 2'b11, 16'h0000, 16'h0000, 1'b0, 32'h0304_0102};
      vtime   = '{21'h00055, 4'b0000, 32'h0000_0000, 16'h0000, 16'h0000, 0, 1, 64, 22'h000AA,  22'h00000,  2'b11, 2'b00, 16'h0000, 16'h0000, 1'b0, 32'hFFFF_FFFF};

      bus.cpu_valid = 1'b0;
      bus.cpu_addr  = '0;
      bus.cpu_wstrb = '0;
      bus.cpu_wdata = '0;

      resetn = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checkResetOutputs("reset");
      resetn = 1'b1;
      @(negedge clk);
      #1;

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i], lat, rd, got);
         checkOutput(vecs[i], $sformatf("v%0d", i), lat, rd, got);
         checkValue($sformatf("v%0d_err", i), bus.cpu_err, 0);
      end

      $display("[TB] slow controller: ack after 10 cycles, held 7");
      ack_delay = 10;
      ack_hold  = 7;
      applyStimulus(vdelay, lat, rd, got);
      checkOutput(vdelay, "delay", lat, rd, got);
      checkValue("delay_req_dropped_early", drop_viol, 0);
      checkValue("delay_req_during_ack", reraise_viol, 0);
      ack_delay = 1;
      ack_hold  = 4;

      $display("[TB] controller never acks");
      never_ack = 1'b1;
      applyStimulus(vtime, lat, rd, got);
      checkOutput(vtime, "timeout", lat, rd, got);
      checkValue("timeout_err", bus.cpu_err, 1);
      checkValue("timeout_rv_req", bus.rv_req, 0);
      never_ack = 1'b0;

      $display("[TB] reset asserted in the middle of the high half");
      model_lo      = 16'h1111;
      model_hi      = 16'h2222;
      req_count     = 0;
      bus.cpu_addr  = 21'h00200;
      bus.cpu_wstrb = 4'b0000;
      bus.cpu_valid = 1'b1;
      waited = 0;
      while (req_count < 2 && waited < 100) begin
         @(negedge clk);
         #1;
         waited++;
      end
      checkValue("midreset_hi_request_seen", (req_count >= 2), 1);
      repeat (3) @(negedge clk);
      #1;
      resetn = 1'b0;
      #1;
      checkResetOutputs("midreset");
      bus.cpu_valid = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      resetn = 1'b1;
      @(negedge clk);
      #1;

      applyStimulus(vecs[8], lat, rd, got);
      checkOutput(vecs[8], "after_reset", lat, rd, got);
      checkValue("after_reset_err", bus.cpu_err, 0);
      checkValue("total_req_dropped_early", drop_viol, 0);
      checkValue("total_req_during_ack", reraise_viol, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
